// File: rtl/nn_pkg.sv
// Shared defaults, FSM encoding and saturation helpers for the neural-network datapath blocks.
package nn_pkg;

    localparam int unsigned DefN    = 8;
    localparam int unsigned DefFrac = 4;
    localparam int unsigned DefAccW = 24;

    typedef enum logic [1:0] {
        StAcc   = 2'd0,
        StFlush = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic int sat_max(input int unsigned n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned n);
        return -(1 << (n - 1));
    endfunction

    localparam int SatMax = sat_max(DefN);
    localparam int SatMin = sat_min(DefN);

endpackage

// File: rtl/fxp_requant.sv
// Requantises a wide signed accumulator to N bits: optional round-half-up, arithmetic shift, clip.
// Rounding is enabled by defining NEURON_MAC_ROUND_EN; otherwise the shift truncates.
module fxp_requant
    import nn_pkg::*;
#(
    parameter int unsigned ACC_W = DefAccW,
    parameter int unsigned N     = DefN,
    parameter int unsigned FRAC  = DefFrac
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [N-1:0]     res,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] MaxV = ACC_W'(sat_max(N));
    localparam logic signed [ACC_W-1:0] MinV = ACC_W'(sat_min(N));

    logic signed [ACC_W-1:0] acc_rnd;
    logic signed [ACC_W-1:0] shifted;

`ifdef NEURON_MAC_ROUND_EN
    if (FRAC > 0) begin : g_round
        localparam logic signed [ACC_W-1:0] Half = ACC_W'(1) <<< (FRAC - 1);
        assign acc_rnd = acc + Half;
    end else begin : g_no_round
        assign acc_rnd = acc;
    end
`else
    assign acc_rnd = acc;
`endif

    assign shifted = acc_rnd >>> FRAC;

    always_comb begin
        res = N'(shifted);
        sat = 1'b0;
        if (shifted > MaxV) begin
            res = N'(MaxV);
            sat = 1'b1;
        end else if (shifted < MinV) begin
            res = N'(MinV);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming signed fixed-point MAC neuron: registered product, accumulate with bias, requantise.
// Build option NEURON_MAC_ROUND_EN selects round-half-up requantisation (see fxp_requant).
module neuron_mac
    import nn_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned FRAC  = DefFrac,
    parameter int unsigned ACC_W = DefAccW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_x,
    input  logic signed [N-1:0] in_w,
    input  logic                in_last,
    input  logic signed [N-1:0] bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out,
    output logic                out_sat
);

    state_e state_q;

    logic                    in_ready_q;
    logic                    out_valid_q;
    logic signed [N-1:0]     out_q;
    logic                    out_sat_q;
    logic                    first_q;

    logic signed [2*N-1:0]   p_q;
    logic                    p_vld_q;
    logic                    p_last_q;
    logic                    p_first_q;
    logic signed [N-1:0]     p_bias_q;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    logic signed [2*N-1:0]   prod;
    logic signed [N-1:0]     rq_res;
    logic                    rq_sat;
    logic                    beat;

    assign beat = in_valid && in_ready_q;
    assign prod = in_x * in_w;

    always_comb begin
        acc_d = acc_q;
        if (p_vld_q) begin
            if (p_first_q) begin
                acc_d = (ACC_W'(p_bias_q) <<< FRAC) + ACC_W'(p_q);
            end else begin
                acc_d = acc_q + ACC_W'(p_q);
            end
        end
    end

    // Requantiser sees the folded value so out is loaded on the same edge as the last fold.
    fxp_requant #(
        .ACC_W (ACC_W),
        .N     (N),
        .FRAC  (FRAC)
    ) u_requant (
        .acc (acc_d),
        .res (rq_res),
        .sat (rq_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StAcc;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_sat_q   <= 1'b0;
            first_q     <= 1'b1;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            p_last_q    <= 1'b0;
            p_first_q   <= 1'b0;
            p_bias_q    <= '0;
            acc_q       <= '0;
        end else begin
            p_vld_q <= beat;
            if (beat) begin
                p_q       <= prod;
                p_last_q  <= in_last;
                p_first_q <= first_q;
                p_bias_q  <= bias;
                first_q   <= in_last;
            end
            acc_q <= acc_d;

            case (state_q)
                StAcc: begin
                    if (beat && in_last) begin
                        state_q    <= StFlush;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                StFlush: begin
                    if (p_vld_q && p_last_q) begin
                        state_q     <= StDone;
                        out_q       <= rq_res;
                        out_sat_q   <= rq_sat;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StAcc;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StAcc;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed-vector bench for neuron_mac (N=8, FRAC=4); expected values hand-computed.
module tb_neuron_mac;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_x;
    logic signed [7:0] in_w;
    logic              in_last;
    logic signed [7:0] bias;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out;
    logic              out_sat;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_mac #(
        .N     (8),
        .FRAC  (4),
        .ACC_W (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_sat   (out_sat)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_beat(input int x, input int w, input bit last, input int b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_x     = 8'(x);
        in_w     = 8'(w);
        in_last  = last;
        bias     = 8'(b);
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x     = 8'sh55;
        in_w     = 8'sh55;
        in_last  = 1'b1;
        bias     = 8'sh55;
    endtask

    // Called right after the last beat's accepting edge.
    task automatic expect_result(input string tag, input int exp_out, input int exp_sat);
        check({tag, "_valid_t1"}, int'(out_valid), 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_t2"}, int'(out_valid), 1);
        check({tag, "_out"}, int'(out), exp_out);
        check({tag, "_sat"}, int'(out_sat), exp_sat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_ready_back"}, int'(in_ready), 1);
        check({tag, "_out_hold"}, int'(out), exp_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rnd_pos;
        int exp_rnd_neg;
`ifdef NEURON_MAC_ROUND_EN
        exp_rnd_pos = 1;
        exp_rnd_neg = 0;
`else
        exp_rnd_pos = 0;
        exp_rnd_neg = -1;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", int'(in_ready), 1);

        // 3 x (16*32) = 1536 -> 96; bias on later beats and idle gap are ignored.
        send_beat(16, 32, 1'b0, 0);
        send_beat(16, 32, 1'b0, 50);
        repeat (4) @(posedge clk);
        #1;
        send_beat(16, 32, 1'b1, -70);
        expect_result("basic", 96, 0);

        // -16<<4 + 256 = 0
        send_beat(16, 16, 1'b1, -16);
        expect_result("cancel", 0, 0);

        // 4 x 16129 -> 4032 clips high
        send_beat(127, 127, 1'b0, 0);
        send_beat(127, 127, 1'b0, 0);
        send_beat(127, 127, 1'b0, 0);
        send_beat(127, 127, 1'b1, 0);
        expect_result("sat_pos", 127, 1);

        // 2 x -16256 -> -2032 clips low
        send_beat(-128, 127, 1'b0, 0);
        send_beat(-128, 127, 1'b1, 0);
        expect_result("sat_neg", -128, 1);

        // 256 - 768 = -512 -> -32 in both builds
        send_beat(-32, 24, 1'b1, 16);
        expect_result("neg_bias", -32, 0);

        send_beat(1, 8, 1'b1, 0);
        expect_result("round_pos", exp_rnd_pos, 0);
        send_beat(-1, 8, 1'b1, 0);
        expect_result("round_neg", exp_rnd_neg, 0);

        // Backpressure: 512 -> 32 held while a new beat waits.
        send_beat(16, 32, 1'b1, 0);
        @(posedge clk);
        #1;
        check("bp_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        in_x     = 8'sd16;
        in_w     = 8'sd16;
        in_last  = 1'b1;
        bias     = 8'sd0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out", int'(out), 32);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_valid_drop", int'(out_valid), 0);
        check("bp_ready_back", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_result("bp_next", 16, 0);

        // Reset mid-vector discards the partial sum.
        send_beat(16, 16, 1'b0, 32);
        send_beat(16, 16, 1'b0, 32);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rel_ready", int'(in_ready), 1);
        check("mid_rel_valid", int'(out_valid), 0);
        send_beat(0, 0, 1'b1, 16);
        expect_result("after_rst", 16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential signed fixed-point multiply-accumulate neuron.
- Consumes a stream of (activation, weight) pairs for one neuron and adds a bias.
- Requantises the sum back to N bits and presents the pre-activation to the downstream ReLU stage.
- Sits directly upstream of the activation block in each layer datapath; its N-bit output feeds the activation input unchanged.

Parameters:
- N, 8: data width of activations, weights, bias and output; signed two's complement, Q(N-1-FRAC).FRAC.
- FRAC, 4: fractional bits of all N-bit operands; 0 <= FRAC < N.
- ACC_W, 24: accumulator width; must be >= 2N; the integrator sizes it for the worst-case fan-in.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat.
- in_x  in  N  signed activation.
- in_w  in  N  signed weight.
- in_last  in  1  final beat of current vector.
- bias  in  N  signed bias, Q format as in_x; sampled on first beat of each vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  N  signed requantised pre-activation.
- out_sat  out  1  result was clipped; qualified by out_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State ACC, out_valid=0, out=0, out_sat=0.
  - Accumulator=0 and first-beat flag=1.
  - Pipeline product register invalid.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after reset release.
  - Reset mid-vector discards all partial state; no output is produced for the aborted vector.
- Beat accepted when in_valid && in_ready.
- Stage 1 (register): product p = in_x*in_w, 2N-bit signed. Stage 1 also registers last, first flag and bias.
- Stage 2 (accumulate), applied to the registered product:
  - First beat: acc = sext(bias) <<< FRAC + sext(p).
  - Other beats: acc = acc + sext(p).
  - Arithmetic is modulo 2^ACC_W; there is no internal saturation.
- First-beat flag: set after reset and after every accepted last beat; cleared by any accepted non-last beat.
- FSM states:
  - ACC: in_ready=1, out_valid=0. Accepted beat with in_last=1 -> FLUSH.
  - FLUSH: in_ready=0. Stage 2 folds the last product, then the requantiser loads out/out_sat -> DONE.
  - DONE: in_ready=0, out_valid=1. out/out_sat held stable. out_ready=1 -> ACC.
- Latency: last beat accepted at cycle t gives out_valid=1 at t+2.
- Next vector beat can be accepted at the cycle after the output handshake.
- Requantise:
  - r = acc >>> FRAC (arithmetic shift).
  - Saturate to [-2^(N-1), 2^(N-1)-1].
  - out_sat=1 iff clipping occurred.
- After handshake, out keeps its value but out_valid=0.
- Single-beat vector (first and last on one beat) is legal.
- in_valid=0 mid-vector: accumulator holds indefinitely.
- in_x/in_w/in_last/bias are ignored when no beat is accepted.

Optional Feature:
- Macro: NEURON_MAC_ROUND_EN.
- Defined: requantise adds 2^(FRAC-1) to acc before the shift (round half up), then saturates. For FRAC=0 the add is omitted.
- Undefined: plain arithmetic shift, i.e. truncation toward -infinity.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package nn_pkg:
  - Default N, FRAC, ACC_W.
  - FSM state encodings ACC/FLUSH/DONE.
  - Localparams for saturation limits (max/min of N-bit signed).
- One natural combinational sub-module, fxp_requant:
  - Parameters ACC_W, N, FRAC.
  - acc in; out and sat out.
  - Contains rounding (under the macro), shift and saturation.
  - Reusable by later layer blocks.

Test Plan (N=8, FRAC=4):
- Basic accumulate:
  - Stimulus: bias=0; 3 beats x=16, w=32, last on 3rd.
  - Response: out=96, out_sat=0, out_valid exactly 2 cycles after last accepted.
- Bias and cancellation:
  - Stimulus: bias=-16; 1 beat x=16, w=16, last.
  - Response: out=0, out_sat=0.
- Saturation, positive:
  - Stimulus: 4 beats x=127, w=127.
  - Response: out=127, out_sat=1.
- Saturation, negative:
  - Stimulus: 2 beats x=-128, w=127.
  - Response: out=-128, out_sat=1.
- Rounding:
  - Stimulus: bias=0; 1 beat x=1, w=8.
  - Response: out=0 without macro, out=1 with NEURON_MAC_ROUND_EN.
  - Stimulus: x=-1, w=8.
  - Response: out=-1 without macro, out=0 with macro.
- Backpressure and reset:
  - Stimulus: hold out_ready=0 for 5 cycles.
  - Response: out stable, in_ready=0, presented beats not consumed; after handshake, in_ready=1 the next cycle.
  - Stimulus: rst_n=0 after 2 beats of a vector.
  - Response: out_valid=0. A following 1-beat vector (bias=16, x=0, w=0) gives out=16.
